// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the mm:ss stopwatch controller: FSM state
// encoding, BCD digit limits and a small helper for the mod-60 stages.
package stopwatch_ctrl_pkg;

  // 2'd3 is left unused; the controller treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  // True when a BCD pair reads 59, the last value before a mod-60 wrap.
  function automatic logic bcd_at_max(input logic [3:0] ones, input logic [3:0] tens);
    return (ones == BCD_UNITS_MAX) && (tens == BCD_TENS_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// One BCD mod-60 stage (00..59). Two of these are chained so the seconds
// carry-out advances the minutes stage in the same clock edge.
module bcd_mod60
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       co
);

  // Carry is combinational so the next stage increments on the same edge as the wrap.
  always_comb begin
    co = inc && bcd_at_max(ones, tens);
  end

  // BCD increment: units roll 9->0 into tens, tens roll 5->0 back to 00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (ones == BCD_UNITS_MAX) begin
        ones <= 4'd0;
        if (tens == BCD_TENS_MAX) begin
          tens <= 4'd0;
        end else begin
          tens <= tens + 4'd1;
        end
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch controller. Owns the run/pause/idle FSM, the tick
// prescaler, the lap-freeze flag, the sticky overflow flag and the
// registered display digits fed to the 7-segment driver.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       frozen,
  output logic       overflow
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;

  logic [3:0] live_sec_ones;
  logic [3:0] live_sec_tens;
  logic [3:0] live_min_ones;
  logic [3:0] live_min_tens;
  logic       sec_co;
  logic       min_co;

  // A tick fires on the last prescaler phase of a RUN cycle, even if start_stop pauses on that edge.
  always_comb begin
    tick = (state == ST_RUN) && (presc == PRESC_LAST);
  end

  bcd_mod60 u_seconds (
    .clk  (clk),
    .rst  (rst),
    .inc  (tick),
    .clr  (clr),
    .ones (live_sec_ones),
    .tens (live_sec_tens),
    .co   (sec_co)
  );

  bcd_mod60 u_minutes (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_co),
    .clr  (clr),
    .ones (live_min_ones),
    .tens (live_min_tens),
    .co   (min_co)
  );

  // Control FSM with prescaler and lap flag; clr beats start_stop beats lap, losers are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else if (clr) begin
      state   <= ST_IDLE;
      presc   <= '0;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          presc <= '0;
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (start_stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (lap) begin
            frozen <= ~frozen;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (lap) begin
            frozen <= ~frozen;
          end
        end
        default: begin
          state   <= ST_IDLE;
          presc   <= '0;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow, set when the minutes stage wraps 59 -> 00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (min_co) begin
      overflow <= 1'b1;
    end
  end

  // Display digits trail the live count by one cycle and hold while a lap freeze is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (clr) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (!frozen) begin
      sec_ones <= live_sec_ones;
      sec_tens <= live_sec_tens;
      min_ones <= live_min_ones;
      min_tens <= live_min_tens;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (DIV=4). A driver applies pulses on the
// falling edge and pushes the expected outputs from a seconds-based
// reference model into a queue; a monitor pops and compares after every
// rising edge. A few directed checks with fixed values are layered on top.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       clr;
  logic       lap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       frozen;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [18:0] expQ[$];

  // Reference model: live and displayed time as plain seconds 0..3599
  int mLive;
  int mDisp;
  int mPhase;
  bit mStarted;
  bit mRunning;
  bit mFrozen;
  bit mOvf;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clr        (clr),
    .lap        (lap),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .frozen     (frozen),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Pack a time in seconds plus flags into the observed output layout
  function automatic logic [18:0] packDisplay(int secs, bit r, bit f, bit o);
    int mins;
    int s;
    mins = secs / 60;
    s    = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10), r, f, o};
  endfunction

  function automatic logic [18:0] actualOut();
    return {min_tens, min_ones, sec_tens, sec_ones, running, frozen, overflow};
  endfunction

  function automatic void modelReset();
    mLive    = 0;
    mDisp    = 0;
    mPhase   = 0;
    mStarted = 1'b0;
    mRunning = 1'b0;
    mFrozen  = 1'b0;
    mOvf     = 1'b0;
  endfunction

  // One clock edge of stopwatch behaviour, written in whole seconds
  function automatic void modelStep(bit s, bit c, bit l);
    bit tick;
    tick = mRunning && (mPhase == DIV - 1);
    if (c) begin
      modelReset();
      return;
    end
    if (!mFrozen) mDisp = mLive;
    if (tick) begin
      mLive = mLive + 1;
      if (mLive == 3600) begin
        mLive = 0;
        mOvf  = 1'b1;
      end
    end
    if (mRunning) mPhase = (mPhase + 1) % DIV;
    if (s) begin
      if (!mStarted) begin
        mStarted = 1'b1;
        mRunning = 1'b1;
      end else begin
        mRunning = !mRunning;
      end
    end else if (l && mStarted) begin
      mFrozen = !mFrozen;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [18:0] act, input logic [18:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit c, input bit l);
    @(negedge clk);
    start_stop = s;
    clr        = c;
    lap        = l;
    if (!rst) modelReset();
    else      modelStep(s, c, l);
    expQ.push_back(packDisplay(mDisp, mRunning, mFrozen, mOvf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAfterEdge(input string name, input logic [18:0] exp);
    @(posedge clk);
    #1;
    checkOutput(name, actualOut(), exp);
  endtask

  // Monitor: compare DUT outputs with the queued expectation after every rising edge
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("scoreboard", actualOut(), e);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    start_stop = 1'b0;
    clr        = 1'b0;
    lap        = 1'b0;
    rst        = 1'b1;
    modelReset();
    #2 rst = 1'b0;
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    idle(5);

    $display("[TB] start and count to 00:10");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(41);
    checkAfterEdge("start_00_10", packDisplay(10, 1'b1, 1'b0, 1'b0));

    $display("[TB] pause two cycles after a tick, then resume");
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(100);
    checkAfterEdge("pause_hold", packDisplay(11, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);
    checkAfterEdge("resume_no_early_tick", packDisplay(11, 1'b1, 1'b0, 1'b0));
    idle(1);
    checkAfterEdge("resume_tick", packDisplay(12, 1'b1, 1'b0, 1'b0));

    $display("[TB] lap freeze");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(12);
    checkAfterEdge("lap_hold_03", packDisplay(3, 1'b1, 1'b1, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(1);
    checkAfterEdge("lap_release_06", packDisplay(6, 1'b1, 1'b0, 1'b0));

    $display("[TB] clr + start_stop + lap together");
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkAfterEdge("priority_clr", packDisplay(0, 1'b0, 1'b0, 1'b0));

    $display("[TB] async reset mid-run at 00:07");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(28);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset", actualOut(), 19'd0);
    modelReset();
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    checkAfterEdge("post_reset_idle", packDisplay(0, 1'b0, 1'b0, 1'b0));

    $display("[TB] run to 59:59 and wrap");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(3600 * DIV);
    checkAfterEdge("wrap_overflow", packDisplay(3599, 1'b1, 1'b0, 1'b1));
    idle(1);
    checkAfterEdge("wrap_display_zero", packDisplay(0, 1'b1, 1'b0, 1'b1));
    idle(7);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAfterEdge("clr_after_wrap", packDisplay(0, 1'b0, 1'b0, 1'b0));

    $display("[TB] random pulses");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 5) == 0);
    end
    idle(3);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
